// File: rtl/dma_acc_responder.sv
// Accelerator-side scratchpad target for the DMA acc_* interface with fixed read latency
// and per-block write counting. Define ACC_PARITY_EN to store and check even parity per word.
module dma_acc_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned READ_LAT  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] acc_addr,
  input  logic        acc_read,
  input  logic        acc_write,
  input  logic [31:0] acc_wdata,
  output logic [31:0] acc_rdata,
  output logic        acc_ready,
  output logic        acc_rvalid,
  output logic        acc_err,
  input  logic        arm,
  input  logic [15:0] expect_words,
  output logic [15:0] words_written,
  output logic        block_done
);

  // state   | meaning
  // IDLE    | ready; writes complete in place, reads are accepted
  // RD_WAIT | read latency timer running down, requests ignored
  // RESP    | acc_rvalid high for one cycle with latched read data
  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [32:0] SPAN     = 33'(4 * DEPTH);
  localparam logic [3:0]  LAT_LOAD = 4'(READ_LAT - 1);

  state_t        state_q, state_d;
  logic [3:0]    lat_q, lat_d;
  logic [31:0]   mem [DEPTH];
  logic [32:0]   offset;
  logic [AW-1:0] idx_now, idx_q, rd_idx;
  logic          in_range, rng_q, rd_rng;
  logic          accept, wr_acc, rd_acc, both_acc;
  logic          enter_resp, par_bad;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [15:0]   target_q, ww_inc;
  logic          fired_q, done_q;

  // 33-bit subtraction: the borrow bit flags addresses below the window without wrap
  assign offset   = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
  assign in_range = !offset[32] && (offset < SPAN) && (acc_addr[1:0] == 2'b00);
  assign idx_now  = offset[AW+1:2];

  assign accept   = (acc_read || acc_write) && acc_ready;
  assign wr_acc   = accept && acc_write && !acc_read;
  assign rd_acc   = accept && acc_read && !acc_write;
  assign both_acc = accept && acc_read && acc_write;

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    acc_ready  = 1'b0;
    acc_rvalid = 1'b0;
    case (state_q)
      IDLE: begin
        acc_ready = 1'b1;
        if (rd_acc) begin
          if (READ_LAT == 1) begin
            state_d = RESP;
          end else begin
            state_d = RD_WAIT;
            lat_d   = LAT_LOAD;
          end
        end
      end
      RD_WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_d == 4'd0) state_d = RESP;
      end
      RESP: begin
        acc_rvalid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With READ_LAT=1 the response is loaded on the accept edge, before idx_q is valid
  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign rd_idx     = (state_q == IDLE) ? idx_now  : idx_q;
  assign rd_rng     = (state_q == IDLE) ? in_range : rng_q;

  always_ff @(posedge clk) begin
    if (wr_acc && in_range) mem[idx_now] <= acc_wdata;
  end

`ifdef ACC_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_acc && in_range) par_mem[idx_now] <= ^acc_wdata;
  end

  assign par_bad = rd_rng && ((^mem[rd_idx]) != par_mem[rd_idx]);
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lat_q   <= 4'd0;
      idx_q   <= '0;
      rng_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      err_q   <= 1'b0;
      if (rd_acc) begin
        idx_q <= idx_now;
        rng_q <= in_range;
      end
      if (both_acc || (wr_acc && !in_range)) err_q <= 1'b1;
      if (enter_resp) begin
        rdata_q <= rd_rng ? mem[rd_idx] : 32'd0;
        err_q   <= !rd_rng || par_bad;
      end
    end
  end

  assign acc_rdata = rdata_q;
  assign acc_err   = err_q;

  assign ww_inc = (words_written == 16'hFFFF) ? words_written : words_written + 16'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      words_written <= 16'd0;
      target_q      <= 16'd0;
      fired_q       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (arm) begin
        words_written <= 16'd0;
        target_q      <= expect_words;
        fired_q       <= (expect_words == 16'd0);
        done_q        <= (expect_words == 16'd0);
      end else if (wr_acc && in_range) begin
        words_written <= ww_inc;
        if (!fired_q && (ww_inc == target_q)) begin
          done_q  <= 1'b1;
          fired_q <= 1'b1;
        end
      end
    end
  end

  assign block_done = done_q;

endmodule
